data_mem_responder: RTL
=======================

# data_mem_responder

Multi-cycle data-memory responder for the MEM stage of the pipelined RV32 core. It accepts the load/store control codes carried down the ID/EX and EX/MEM pipeline registers (MEM_READ, MEM_WRITE) with address and store data. It performs byte, halfword or word accesses on an internal byte-addressed array with sign or zero extension on loads. It drives BUSY_WAIT, which all pipeline registers use to hold their contents while an access is in progress.

## Interface
- DEPTH_BYTES, 1024: array size in bytes; power of two, multiple of 4.
- LATENCY, 4: number of ACCESS-state cycles per request; must be at least 1.
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MEM_READ  in  3  load code: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 treated as none.
- MEM_WRITE  in  3  store code: 000 none, 001 SB, 010 SH, 011 SW; 100–111 treated as none.
- ADDRESS  in  32  byte address (ALU result); only bits [log2(DEPTH_BYTES)-1:0] are used.
- WRITE_DATA  in  32  store data; SB uses [7:0], SH uses [15:0].
- BUSY_WAIT  out  1  high while a request is pending and not yet complete; pipeline registers hold when high.
- READ_DATA  out  32  registered, extended load result.

## Operation
- Request valid (REQ): MEM_READ or MEM_WRITE carries a non-"none" code. If both are valid, the store wins and READ_DATA is not updated.
- FSM states:
  - IDLE: if REQ at a clock edge, latch code, ADDRESS and WRITE_DATA; clear counter to 1; go to ACCESS.
  - ACCESS: counter increments each edge. At the edge where counter == LATENCY, perform the access and go to DONE.
  - DONE: unconditionally return to IDLE at the next edge.
- BUSY_WAIT (combinational) = (state==IDLE && REQ) || state==ACCESS. It is 0 in DONE and 0 while RESET is low.
- Inputs are ignored outside IDLE. Changes or withdrawal of the request during ACCESS do not abort the access.
- Stores update only the addressed bytes:
  - SB writes byte ADDRESS[1:0].
  - SH writes half ADDRESS[1], with ADDRESS[0] ignored.
  - SW writes the whole word, with ADDRESS[1:0] ignored.
- Loads use the same lane selection. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word little-endian.
- READ_DATA holds its value until the next completed load. Stores do not change it.
- Address bits above the array index wrap modulo DEPTH_BYTES.
- Reset: state←IDLE, counter←0, READ_DATA←0, BUSY_WAIT←0. Array contents are not reset. Reset asserted mid-ACCESS abandons the access, and the array is not written.

## Timing
- Request present in cycle 0: BUSY_WAIT is high in cycles 0..LATENCY, which is LATENCY+1 cycles.
- The access is committed at the end of cycle LATENCY. In cycle LATENCY+1 (DONE), BUSY_WAIT is low and READ_DATA is valid.
- The pipeline advances at the end of cycle LATENCY+1.
- Back-to-back requests: the next request appears in cycle LATENCY+2 (IDLE). It is accepted that cycle with BUSY_WAIT high, with no idle gap beyond DONE.
- A request present only in the DONE cycle is not accepted. This is by design: it is the same instruction, being released.
- Non-memory instructions (both codes none) never raise BUSY_WAIT. Zero stall.
- Reset deassertion: the first request is accepted in the first cycle in which RESET is high.

## Test plan
- Reset: hold RESET low 3 cycles with MEM_READ=011 asserted → BUSY_WAIT=0, READ_DATA=0. Release → BUSY_WAIT rises the same cycle.
- SW then LW, LATENCY=4: SW 0x12345678 to 0x10, then LW 0x10.
  - BUSY_WAIT is high for 5 cycles per request and low 1 cycle between.
  - READ_DATA=0x12345678 in the LW DONE cycle.
- Byte/half extension: SW 0x80FF7F01 at 0x20.
  - LB 0x23→0xFFFFFF80; LBU 0x23→0x00000080.
  - LH 0x22→0xFFFF80FF; LHU 0x20→0x00007F01; LB 0x20→0x00000001.
- Partial stores: SW 0 at 0x30, SB 0xAA at 0x31, SH 0xBEEF at 0x33 (half 1) → LW 0x30 = 0xBEEFAA00.
- Mid-access changes: during ACCESS, change ADDRESS/WRITE_DATA/codes and drop the request → the original access completes, with timing unchanged. Simultaneous MEM_READ=011 and MEM_WRITE=011 → store performed, READ_DATA unchanged.
- Reset mid-ACCESS: SW 0xDEADBEEF to 0x40 over prior 0, assert RESET in counter cycle 2 → BUSY_WAIT drops immediately; a later LW 0x40 returns 0x00000000. Address 0x440 with DEPTH_BYTES=1024 aliases 0x040.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. A load or store is
// latched in IDLE, completes after LATENCY ACCESS cycles, and is released
// through one DONE cycle in which BUSY_WAIT is low and READ_DATA is valid.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  MEM_READ,
    input  logic [2:0]  MEM_WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic        BUSY_WAIT,
    output logic [31:0] READ_DATA
);
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int CNT_W = $clog2(LATENCY + 1) + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic              is_store_q;
    logic [2:0]        code_q;
    logic [AW-1:0]     addr_q;
    logic [31:0]       wdata_q;

    logic [7:0]        mem [DEPTH_BYTES];

    logic              rd_ok, wr_ok, req, commit;
    logic [AW-1:0]     idx0, idx1, idx2, idx3;
    logic [31:0]       word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_val;

    // Address bits above the array index wrap, so they are intentionally dropped.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^ADDRESS[31:AW];

    // Codes outside the defined sets count as "none".
    assign rd_ok  = (MEM_READ  != 3'd0) && (MEM_READ  <= 3'd5);
    assign wr_ok  = (MEM_WRITE != 3'd0) && (MEM_WRITE <= 3'd3);
    assign req    = rd_ok || wr_ok;
    assign commit = (state == ACCESS) && (counter == CNT_W'(LATENCY));

    // Stall request is gated by reset so the pipeline never holds during reset.
    assign BUSY_WAIT = RESET && (((state == IDLE) && req) || (state == ACCESS));

    // Byte indices of the aligned word containing the latched address.
    assign idx0 = {addr_q[AW-1:2], 2'd0};
    assign idx1 = {addr_q[AW-1:2], 2'd1};
    assign idx2 = {addr_q[AW-1:2], 2'd2};
    assign idx3 = {addr_q[AW-1:2], 2'd3};
    assign word = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};

    // Lane selection and sign/zero extension of the load result.
    always_comb begin
        byte_v   = word[8*addr_q[1:0] +: 8];
        half_v   = addr_q[1] ? word[31:16] : word[15:0];
        load_val = 32'd0;
        case (code_q)
            3'd1:    load_val = {{24{byte_v[7]}}, byte_v};
            3'd2:    load_val = {{16{half_v[15]}}, half_v};
            3'd3:    load_val = word;
            3'd4:    load_val = {24'd0, byte_v};
            3'd5:    load_val = {16'd0, half_v};
            default: load_val = 32'd0;
        endcase
    end

    // Request FSM: latch in IDLE, count through ACCESS, release via DONE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            counter    <= '0;
            is_store_q <= 1'b0;
            code_q     <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            READ_DATA  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Store wins when both codes are valid.
                        is_store_q <= wr_ok;
                        code_q     <= wr_ok ? MEM_WRITE : MEM_READ;
                        addr_q     <= ADDRESS[AW-1:0];
                        wdata_q    <= WRITE_DATA;
                        counter    <= CNT_W'(1);
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    counter <= counter + CNT_W'(1);
                    if (commit) begin
                        if (!is_store_q) READ_DATA <= load_val;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array write on the commit edge; contents are never reset.
    always_ff @(posedge CLK) begin
        if (RESET && commit && is_store_q) begin
            case (code_q)
                3'd1: mem[addr_q] <= wdata_q[7:0];
                3'd2: begin
                    mem[{addr_q[AW-1:1], 1'b0}] <= wdata_q[7:0];
                    mem[{addr_q[AW-1:1], 1'b1}] <= wdata_q[15:8];
                end
                3'd3: begin
                    mem[idx0] <= wdata_q[7:0];
                    mem[idx1] <= wdata_q[15:8];
                    mem[idx2] <= wdata_q[23:16];
                    mem[idx3] <= wdata_q[31:24];
                end
                default: ;
            endcase
        end
    end
endmodule
